// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter that lets NUM_REQ requesters share a
//                single DATA_W-bit register. Each accepted write locks the
//                register for HOLD_CYCLES cycles before the next write.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          q,
    output logic                       q_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Counter load value on entering HOLD; unused when HOLD_CYCLES is 0.
    localparam logic [CNT_W-1:0] c_HOLD_LOAD =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [ID_W:0]    c_NUM_REQ   = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  c_LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [DATA_W-1:0] r_q;
    logic              r_q_valid;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_busy;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W:0]     w_idx;
    logic [ID_W-1:0]   w_next_ptr;
    logic [DATA_W-1:0] w_win_data;

    // Priority search starting at the round-robin pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= c_NUM_REQ) begin
                w_idx = w_idx - c_NUM_REQ;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    // Grant is only offered while IDLE and out of reset, so nothing can
    // handshake while the register is locked or being cleared.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign w_next_ptr = (w_winner == c_LAST_ID) ? '0 : (w_winner + 1'b1);
    assign w_win_data = req_data[w_winner*DATA_W +: DATA_W];

    // Arbitration FSM: capture the winner in IDLE, then count down the lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_q        <= w_win_data;
                        r_q_valid  <= 1'b1;
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_next_ptr;
                        if (HOLD_CYCLES > 0) begin
                            r_state    <= S_HOLD;
                            r_busy     <= 1'b1;
                            r_hold_cnt <= c_HOLD_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule
`default_nettype wire
